// File: rtl/uart_out.sv
// uart_out: buffered 8N1 UART transmitter, LSB first.
//
// Bytes written via send/ready are queued in a DEPTH-entry FIFO and shifted
// out on uart_tx, each bit lasting CLKS_PER_BIT clocks. Consecutive queued
// bytes are sent back to back with no idle gap between frames.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset; aborts any frame in flight
//   byte_out in   byte to transmit, captured when send && ready
//   send     in   one-cycle write strobe
//   ready    out  FIFO not full (registered)
//   uart_tx  out  serial line, idle high, driven from a flop
//   busy     out  frame in progress or FIFO non-empty
//   overflow out  sticky: send seen while ready was low; cleared by reset only
module uart_out #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_out,
    input  logic       send,
    output logic       ready,
    output logic       uart_tx,
    output logic       busy,
    output logic       overflow
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0]   BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_timer, w_timer_nxt;
    logic [2:0]      r_idx,   w_idx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_tx,    w_tx_nxt;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count, w_count_nxt;
    logic            r_ready;
    logic            r_overflow;

    logic            w_wr;
    logic            w_rd;
    logic            w_nonempty;
    logic            w_bit_last;
    logic [7:0]      w_head;

    // Acceptance uses the registered ready, so a pop in a full cycle cannot
    // make that same cycle's send accepted.
    assign w_wr       = send && r_ready;
    assign w_nonempty = (r_count != '0);
    assign w_bit_last = (r_timer == BIT_LAST);
    assign w_head     = r_mem[r_rptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd)
            w_count_nxt = r_count + CNT_ONE;
        else if (!w_wr && w_rd)
            w_count_nxt = r_count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= byte_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + PTR_ONE;
            if (w_rd)
                r_rptr <= r_rptr + PTR_ONE;
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != FULL_CNT);
            if (send && !r_ready)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = w_bit_last ? '0 : r_timer + 16'd1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_rd        = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if (w_nonempty) begin
                    w_rd        = 1'b1;
                    w_shift_nxt = w_head;
                    w_idx_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_last)
                    w_state_nxt = DATA;
            end
            DATA: begin
                if (w_bit_last) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7)
                        w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_last) begin
                    // Chain straight into the next start bit when data waits.
                    if (w_nonempty) begin
                        w_rd        = 1'b1;
                        w_shift_nxt = w_head;
                        w_idx_nxt   = '0;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Line level is registered from the next state so it is glitch-free.
        unique case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign ready    = r_ready;
    assign uart_tx  = r_tx;
    assign busy     = (r_state != IDLE) || w_nonempty;
    assign overflow = r_overflow;

endmodule

// File: doc/uart_out.md
# uart_out

UART transmitter: the transmit-side counterpart of the `uart_in` receiver. It accepts bytes from fabric logic through a valid/ready strobe, buffers them in a small FIFO, and serialises them onto `uart_tx` as 8N1 frames, LSB first. It sits beside `uart_in` in the top level, so the board can echo characters or report LCD/controller status back to the host.

## Interface
- `CLKS_PER_BIT`, 234: clock cycles per bit (27 MHz / 115200); legal range 2..65535.
- `DEPTH`, 16: FIFO depth in bytes; power of two, 2..256.
- `clk` in 1: system clock; all logic is synchronous to its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `byte_out` in 8: byte to transmit; sampled when `send && ready`.
- `send` in 1: write strobe, one cycle per byte.
- `ready` out 1: FIFO not full (`!full`, registered).
- `uart_tx` out 1: serial line; idle high.
- `busy` out 1: high while a frame is in progress or the FIFO is non-empty.
- `overflow` out 1: sticky; set when `send` is high while `ready` is low.

## Operation
- Reset values:
  - `uart_tx`=1, `ready`=1, `busy`=0, `overflow`=0.
  - FIFO read/write pointers and count are 0, FSM is IDLE, bit timer is 0.
- FIFO:
  - Write occurs when `send && ready`.
  - Read occurs when the FSM pops.
  - A simultaneous read and write leaves count unchanged.
  - `ready` is derived from the registered count. When full, a same-cycle pop does not make that cycle's `send` accepted.
- Overflow: when `send && !ready`, the byte is dropped and `overflow` is set. Only reset clears it.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: `uart_tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit timer and bit index, and go to START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `uart_tx`=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the 3-bit index. After index 7, go to STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles. On the final cycle:
    - FIFO non-empty: pop and go straight to START, with no idle gap.
    - FIFO empty: go to IDLE.
- The bit timer is a 16-bit up-counter that wraps to 0 at CLKS_PER_BIT-1.
- `uart_tx` is driven from a flop, so the line never glitches.
- `busy` = (state != IDLE) || (count != 0).
- Reset mid-frame: `uart_tx` returns high immediately (asynchronous), the frame is aborted and queued bytes are discarded.

## Timing
- Latency: for a byte written at edge N into an empty FIFO with the FSM in IDLE, the pop happens at edge N+1 and `uart_tx` goes low after edge N+1.
- Frame length: exactly 10×CLKS_PER_BIT cycles (start, 8 data bits, stop). Each bit lasts exactly CLKS_PER_BIT cycles with no drift.
- Back-to-back bytes: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Handshake:
  - `ready` falls the cycle after the write that fills the FIFO.
  - `ready` rises the cycle after the pop that makes it non-full.
- `busy` rises the cycle after the first accepted write. It falls the cycle after the last stop bit completes with the FIFO empty.

## Test plan
All scenarios use CLKS_PER_BIT=4, DEPTH=4.
- Reset idle:
  - Hold `rst_n`=0, then release.
  - Required: `uart_tx`=1, `ready`=1, `busy`=0, `overflow`=0 for 50 cycles with `send`=0.
- Single byte:
  - Send 0x41 at edge N.
  - Required: `uart_tx` low from N+1 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4 cycles.
  - Required: `busy` falls 40 cycles after N+1.
- Back-to-back:
  - Send 0x55 then 0xAA on consecutive cycles.
  - Required: two frames totalling 80 cycles with no idle gap; decoded bytes are 0x55 then 0xAA.
- Full/overflow:
  - Send 6 bytes (0x01..0x06) on consecutive cycles.
  - Required: 0x01 is popped at once and the FIFO fills with 0x02..0x05, so `ready`=0 from the cycle after the 0x05 write.
  - Required: 0x06 is dropped and `overflow`=1 stays set.
  - Required: the line carries exactly 0x01..0x05.
- Reset mid-frame:
  - Assert `rst_n`=0 during bit 3 of 0x0F with 2 bytes queued.
  - Required: `uart_tx`=1 in the same cycle; after release the line stays idle, `busy`=0 and `ready`=1.
- Simultaneous push/pop:
  - With the FIFO full, drive `send` on the cycle the FSM pops.
  - Required: that byte is not accepted and `overflow` is set.
  - Required: on the next cycle, `ready`=1 and a write is accepted.
